// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one LED among four requesters; each granted
// requester gets a burst of N blinks followed by a dark gap and a done pulse.
module led_blink_arbiter #(
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned OFF_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] count,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic        led
);

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned BLINK_W = 5;
    localparam logic [PHASE_W-1:0] ON_LAST  = PHASE_W'(ON_CYCLES - 1);
    localparam logic [PHASE_W-1:0] OFF_LAST = PHASE_W'(OFF_CYCLES - 1);
    localparam logic [PHASE_W-1:0] GAP_LAST = PHASE_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t               state;
    logic [PHASE_W-1:0]   phase;
    logic [BLINK_W-1:0]   blinks;
    logic [1:0]           ptr;
    logic [1:0]           winner;
    logic                 aborted;

    logic                 pick_valid;
    logic [1:0]           pick_idx;
    logic [1:0]           cand;
    logic [3:0]           pick_nib;
    logic [BLINK_W-1:0]   pick_count;

    // Round-robin search starting just after the last winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // A zero nibble encodes a full burst of sixteen blinks.
    always_comb begin
        pick_nib   = count[{pick_idx, 2'b00} +: 4];
        pick_count = (pick_nib == 4'd0) ? BLINK_W'(16) : {1'b0, pick_nib};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            blinks  <= '0;
            ptr     <= 2'd3;
            winner  <= 2'd0;
            aborted <= 1'b0;
            grant   <= 4'b0;
            done    <= 4'b0;
            busy    <= 1'b0;
            led     <= 1'b0;
        end else begin
            done <= 4'b0;
            case (state)
                IDLE: begin
                    // The cycle carrying a done pulse never grants.
                    if (done == 4'b0 && pick_valid) begin
                        state   <= ON;
                        phase   <= '0;
                        blinks  <= pick_count;
                        ptr     <= pick_idx;
                        winner  <= pick_idx;
                        aborted <= 1'b0;
                        grant   <= 4'b0001 << pick_idx;
                        busy    <= 1'b1;
                        led     <= 1'b1;
                    end
                end
                ON: begin
                    if (!req[winner]) begin
                        state   <= GAP;
                        phase   <= '0;
                        led     <= 1'b0;
                        aborted <= 1'b1;
                    end else if (phase == ON_LAST) begin
                        state <= OFF;
                        phase <= '0;
                        led   <= 1'b0;
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                OFF: begin
                    if (!req[winner]) begin
                        state   <= GAP;
                        phase   <= '0;
                        led     <= 1'b0;
                        aborted <= 1'b1;
                    end else if (phase == OFF_LAST) begin
                        blinks <= blinks - BLINK_W'(1);
                        phase  <= '0;
                        if (blinks == BLINK_W'(1)) begin
                            state <= GAP;
                        end else begin
                            state <= ON;
                            led   <= 1'b1;
                        end
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                GAP: begin
                    if (phase == GAP_LAST) begin
                        state <= IDLE;
                        phase <= '0;
                        grant <= 4'b0;
                        busy  <= 1'b0;
                        if (!aborted) begin
                            done <= 4'b0001 << winner;
                        end
                    end else begin
                        phase <= phase + PHASE_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: directed scenarios plus random requesters,
// checked every cycle against a schedule-based reference model.
module tb_led_blink_arbiter;

    localparam int ON  = 4;
    localparam int OFF = 4;
    localparam int GAP = 8;
    localparam int PER = ON + OFF;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] count;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        led;

    led_blink_arbiter #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .count (count),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .led   (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc;

    // Reference model: one service record described by its schedule.
    logic have_svc;
    int   s_t, s_w, s_gap, s_end;
    logic s_abort;
    int   m_ptr;
    logic [3:0] e_done_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        have_svc    = 1'b0;
        s_t = 0; s_w = 0; s_gap = 0; s_end = 0;
        s_abort     = 1'b0;
        m_ptr       = 3;
        e_done_last = 4'b0;
    endtask

    task automatic model_update(input int c, input logic [3:0] r, input logic [15:0] cn);
        logic idle, dn, found;
        int   j, n;
        logic [3:0] nib;
        if (have_svc && !s_abort && c >= s_t + 1 && c < s_gap && !r[s_w]) begin
            s_abort = 1'b1;
            s_gap   = c + 1;
            s_end   = c + 1 + GAP;
        end
        idle  = !have_svc || c >= s_end;
        dn    = have_svc && c == s_end && !s_abort;
        found = 1'b0;
        if (idle && !dn && r != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
                j = (m_ptr + k) % 4;
                if (!found && r[j]) begin
                    found    = 1'b1;
                    nib      = 4'(cn >> (4 * j));
                    n        = (nib == 4'd0) ? 16 : int'(nib);
                    have_svc = 1'b1;
                    s_t      = c;
                    s_w      = j;
                    s_gap    = c + 1 + n * PER;
                    s_end    = s_gap + GAP;
                    s_abort  = 1'b0;
                    m_ptr    = j;
                end
            end
        end
    endtask

    // Advance one cycle: check outputs of the new cycle, then apply its inputs.
    task automatic step(input logic [3:0] r, input logic [15:0] cn);
        logic       in_svc, e_led;
        logic [3:0] e_grant, e_done;
        @(posedge clock);
        #1;
        cyc++;
        in_svc  = have_svc && cyc >= s_t + 1 && cyc < s_end;
        e_grant = in_svc ? (4'b0001 << s_w) : 4'b0;
        e_led   = in_svc && cyc < s_gap && (((cyc - s_t - 1) % PER) < ON);
        e_done  = (have_svc && cyc == s_end && !s_abort) ? (4'b0001 << s_w) : 4'b0;
        chk($sformatf("led@%0d", cyc),   32'(led),   32'(e_led));
        chk($sformatf("grant@%0d", cyc), 32'(grant), 32'(e_grant));
        chk($sformatf("done@%0d", cyc),  32'(done),  32'(e_done));
        chk($sformatf("busy@%0d", cyc),  32'(busy),  32'(in_svc));
        e_done_last = e_done;
        req   = r;
        count = cn;
        model_update(cyc, r, cn);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_led"},   32'(led),   32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
    endtask

    // Reset with the release between edges so the next edge starts cycle 0.
    task automatic reset_dut();
        reset = 1'b1;
        req   = 4'b0;
        count = 16'h0;
        repeat (2) @(posedge clock);
        #1;
        outputs_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        cyc   = -1;
        model_reset();
    endtask

    initial begin
        logic [3:0]  rq;
        logic [15:0] cn;
        int          led_hi;
        logic [3:0]  done_seen;

        reset = 1'b1;
        req   = 4'b0;
        count = 16'h0;
        cyc   = -1;
        model_reset();

        // Single request, two blinks
        reset_dut();
        led_hi = 0;
        for (int c = 0; c <= 27; c++) begin
            step((c <= 25) ? 4'b0001 : 4'b0000, 16'h0002);
            if (led === 1'b1) led_hi++;
            if (cyc == 1)  chk("single_grant1", 32'(grant), 32'h1);
            if (cyc == 25) chk("single_done25", 32'(done), 32'h1);
            if (cyc == 25) chk("single_grant25", 32'(grant), 32'h0);
        end
        chk("single_led_cycles", 32'(led_hi), 32'd8);

        // Simultaneous requests, then re-request after both served
        reset_dut();
        for (int c = 0; c <= 38; c++) begin
            rq[0] = (c <= 17) || (c >= 36);
            rq[1] = 1'b0;
            rq[2] = (c <= 35) || (c >= 36);
            rq[3] = 1'b0;
            step(rq, 16'h0101);
            if (cyc == 17) chk("simul_done17", 32'(done), 32'h1);
            if (cyc == 19) chk("simul_grant19", 32'(grant), 32'h4);
            if (cyc == 35) chk("simul_done35", 32'(done), 32'h4);
            if (cyc == 37) chk("simul_rr_grant", 32'(grant), 32'h1);
        end

        // Count zero means sixteen blinks
        reset_dut();
        led_hi = 0;
        for (int c = 0; c <= 139; c++) begin
            step((c <= 137) ? 4'b1000 : 4'b0000, 16'h0000);
            if (led === 1'b1) led_hi++;
            if (cyc == 137) chk("zero_done137", 32'(done), 32'h8);
        end
        chk("zero_led_cycles", 32'(led_hi), 32'd64);

        // Abort during second ON
        reset_dut();
        done_seen = 4'b0;
        for (int c = 0; c <= 22; c++) begin
            step((c < 10) ? 4'b0010 : 4'b0000, 16'h0030);
            done_seen = done_seen | done;
            if (cyc == 11) chk("abort_led11", 32'(led), 32'h0);
            if (cyc == 18) chk("abort_grant18", 32'(grant), 32'h2);
            if (cyc == 19) chk("abort_grant19", 32'(grant), 32'h0);
        end
        chk("abort_no_done", 32'(done_seen), 32'h0);

        // Asynchronous reset during a service
        reset_dut();
        for (int c = 0; c <= 2; c++) step(4'b0100, 16'h0500);
        chk("mid_led_before", 32'(led), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        outputs_zero("async_reset");
        reset_dut();
        for (int c = 0; c <= 37; c++) begin
            rq = {2'b00, (c <= 35), (c <= 17)};
            step(rq, 16'h0011);
            if (cyc == 1) chk("post_reset_grant", 32'(grant), 32'h1);
        end

        // Saturation: all requesters held continuously
        reset_dut();
        for (int c = 0; c <= 74; c++) begin
            step(4'b1111, 16'h1111);
            if (cyc == 17) chk("sat_done17", 32'(done), 32'h1);
            if (cyc == 35) chk("sat_done35", 32'(done), 32'h2);
            if (cyc == 53) chk("sat_done53", 32'(done), 32'h4);
            if (cyc == 71) chk("sat_done71", 32'(done), 32'h8);
            if (cyc == 73) chk("sat_grant73", 32'(grant), 32'h1);
        end

        // Random requesters: hold until done, occasionally abandon
        reset_dut();
        rq = 4'b0;
        cn = 16'h0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (rq[i] && e_done_last[i]) rq[i] = 1'b0;
                else if (rq[i] && ($urandom % 96) == 0) rq[i] = 1'b0;
                else if (!rq[i] && ($urandom % 8) == 0) rq[i] = 1'b1;
                if (($urandom % 4) == 0) cn[4*i +: 4] = 4'($urandom % 6);
            end
            step(rq, cn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
